serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Multi-bit adder built from one shared full_adder instance (ports A, B, Cin, S, Cout), time-multiplexed LSB-first at one bit per clock.
- Accepts a WIDTH-bit operand pair plus carry-in on a valid/ready handshake and sequences the full adder through every bit position.
- Holds the completed sum and carry-out on a valid/ready output handshake.
- Area-minimal alternative to a ripple-carry adder in low-throughput datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 1..64.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operands A/B/Cin valid.
- in_ready, output, 1, block can accept operands.
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B.
- Cin, input, 1, carry into bit 0.
- out_valid, output, 1, S/Cout hold a completed result.
- out_ready, input, 1, consumer accepts result.
- S, output, WIDTH, sum.
- Cout, output, 1, carry out of bit WIDTH-1.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - S=0; Cout=0; bit counter=0; carry register=0; operand shift registers=0.
- Reset deassertion is sampled synchronously; first accept is possible on the first rising edge with rst_n high.
- State machine:
  - IDLE -> RUN on an edge where in_valid && in_ready (accept edge). On that edge, latch A and B into shift registers, latch Cin into the carry register, counter=0.
  - RUN: each edge feeds operand-A bit 0, operand-B bit 0 and the carry register into the full adder.
    - S bit [counter] <= full_adder S; carry register <= full_adder Cout.
    - Operand registers shift right by 1; counter increments.
    - On the edge where counter==WIDTH-1: capture Cout <= full_adder Cout, go to DONE.
  - DONE: out_valid=1. On an edge with out_ready=1 -> IDLE, out_valid drops. With out_ready=0, S and Cout stay stable indefinitely.
- Latency: out_valid rises exactly WIDTH edges after the accept edge. Throughput: one result per WIDTH+2 cycles minimum (accept, WIDTH RUN edges, handoff).
- in_ready = (state==IDLE), combinational from state only. in_valid is ignored in RUN/DONE.
- No overlap: an accept and a result handoff never occur on the same edge.
- A/B/Cin may change freely after the accept edge; the result depends only on the latched values.
- S holds its last value through IDLE until the next RUN overwrites it bit by bit. S is only meaningful while out_valid=1.
- Arithmetic: {Cout,S} == A + B + Cin, modulo 2^(WIDTH+1), unsigned.
- Counter width: $clog2(WIDTH), minimum 1 bit. No wrap beyond WIDTH-1.
- WIDTH=1: RUN lasts one edge; out_valid rises one edge after accept.
- Reset mid-RUN or mid-DONE: immediate return to reset values; partial result is discarded and no out_valid pulse occurs.
- out_ready high while not in DONE has no effect.

Test Plan:
- WIDTH=8, accept A=0x00, B=0x00, Cin=0, out_ready=1 -> out_valid high 8 edges after accept, S=0x00, Cout=0; in_ready returns 1 on the following edge.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1. Then A=0xA5, B=0x5A, Cin=1 -> S=0x00, Cout=1. Then A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0.
- Backpressure: A=0x12, B=0x34, Cin=0, out_ready low for 5 cycles after out_valid rises -> S=0x46, Cout=0 stable all 5 cycles. Toggle in_valid and A/B during RUN/DONE -> in_ready=0, result unaffected.
- Reset mid-RUN: accept A=0xF0, B=0x0F, pulse rst_n low for a partial cycle after 3 RUN edges -> out_valid=0, S=0x00, in_ready=1 immediately. A fresh accept of 0x01+0x01+0 then gives S=0x02, Cout=0.
- Random regression, 1000 operand sets with random out_ready stalls -> every {Cout,S} equals A+B+Cin; exactly one out_valid handoff per accept.
- WIDTH=1 build: A=1, B=1, Cin=1 -> S=1, Cout=1, out_valid one edge after accept.

Source files
------------

// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: operand/result valid-ready bundle for the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             busy;
  modport master (
    output in_valid, A, B, Cin, out_ready,
    input  in_ready, out_valid, S, Cout, busy
  );
  modport slave (
    input  in_valid, A, B, Cin, out_ready,
    output in_ready, out_valid, S, Cout, busy
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: WIDTH-bit adder that reuses one full adder, LSB first, one bit per clock
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             w_s;
  logic             w_co;
  full_adder u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_carry),
    .S    (w_s),
    .Cout (w_co)
  );
  // accept operands, step one bit per edge in RUN, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_state <= RUN;
          r_a     <= bus.A;
          r_b     <= bus.B;
          r_carry <= bus.Cin;
          r_cnt   <= '0;
        end
        RUN: begin
          r_s[r_cnt] <= w_s;
          r_carry    <= w_co;
          r_a        <= r_a >> 1;
          r_b        <= r_b >> 1;
          if (r_cnt == LAST) begin
            r_cout  <= w_co;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: if (bus.out_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.S         = r_s;
  assign bus.Cout      = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench comparing results against plain A+B+Cin
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  serial_adder_ctrl_if #(.WIDTH(8)) bus ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();
  serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int handoffs = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  // monitor: every handoff must match the oldest outstanding expected sum
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      handoffs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handoff: got %0h expected none", {bus.Cout, bus.S});
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {55'd0, bus.Cout, bus.S}, {55'd0, mon_e});
      end
    end
  end
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic c, input int stall);
    int n;
    logic [8:0] e;
    e = {1'b0, a} + {1'b0, b} + {8'd0, c};
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.A = a;
    bus.B = b;
    bus.Cin = c;
    bus.out_ready = 1'b0;
    exp_q.push_back(e);
    accepts++;
    @(posedge clk);
    #1;
    chk("in_ready_run", 64'(bus.in_ready), 64'd0);
    chk("busy_run", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      bus.in_valid = 1'($urandom);
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      bus.Cin = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'd8);
    bus.out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'($urandom);
      bus.A = 8'($urandom);
      bus.B = 8'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_result", {55'd0, bus.Cout, bus.S}, {55'd0, e});
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("handoff_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("in_ready_after", 64'(bus.in_ready), 64'd1);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.Cin = 1'b0;
    bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.A = '0;
    bus1.B = '0;
    bus1.Cin = 1'b0;
    bus1.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_result", {55'd0, bus.Cout, bus.S}, 64'd0);
    rst_n = 1'b1;
    run(8'h00, 8'h00, 1'b0, 0);
    run(8'hFF, 8'h01, 1'b0, 0);
    run(8'hA5, 8'h5A, 1'b1, 0);
    run(8'h7F, 8'h01, 1'b0, 0);
    run(8'h12, 8'h34, 1'b0, 5);
    // reset in the middle of RUN discards the partial result
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.A = 8'hF0;
    bus.B = 8'h0F;
    bus.Cin = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_run_busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("mrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst_S", 64'(bus.S), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst_busy", 64'(bus.busy), 64'd0);
    rst_n = 1'b1;
    run(8'h01, 8'h01, 1'b0, 0);
    // single-bit build
    @(negedge clk);
    bus1.in_valid = 1'b1;
    bus1.A = 1'b1;
    bus1.B = 1'b1;
    bus1.Cin = 1'b1;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    chk("w1_not_yet", 64'(bus1.out_valid), 64'd0);
    chk("w1_busy", 64'(bus1.busy), 64'd1);
    @(posedge clk);
    #1;
    chk("w1_valid", 64'(bus1.out_valid), 64'd1);
    chk("w1_result", {62'd0, bus1.Cout, bus1.S}, 64'd3);
    bus1.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus1.out_ready = 1'b0;
    chk("w1_drop", 64'(bus1.out_valid), 64'd0);
    chk("w1_in_ready", 64'(bus1.in_ready), 64'd1);
    for (int k = 0; k < 1000; k++)
      run(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    @(negedge clk);
    chk("handoff_count", 64'(handoffs), 64'(accepts));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
